// File: rtl/pushshift_pkg.sv
// Shared constants for the push/shift bank: default geometry and FSM state encodings.
package pushshift_pkg;

    localparam int unsigned DEF_DW     = 4;
    localparam int unsigned DEF_DIGITS = 6;
    localparam int unsigned DEF_AW     = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

endpackage

// File: rtl/pushshift_ram.sv
// Single-port RAM, synchronous write with asynchronous read so a push sees the pre-write word.
module pushshift_ram
    import pushshift_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW
) (
    input  logic          sysclk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wrData,
    output logic [DW-1:0] rdData_c
);

    localparam int unsigned DEPTH = 2**AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge sysclk) begin
        if (we) begin
            mem[addr] <= wrData;
        end
    end

    assign rdData_c = mem[addr];

endmodule

// File: rtl/pushshift_bank.sv
// RAM-backed push/shift bank: each push writes RAM and shifts the displaced word into a digit register.
module pushshift_bank
    import pushshift_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned AW     = DEF_AW
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 iEn,
    input  logic                 iDir,
    input  logic                 iClr,
    input  logic [AW-1:0]        iAddr,
    input  logic [DW-1:0]        iData,
    output logic [DW*DIGITS-1:0] oData,
    output logic                 oReady,
    output logic                 oDone
);

    localparam int unsigned OW = DW * DIGITS;

    state_t        state;
    state_t        stateNext;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cntNext;
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramWrData;
    logic [DW-1:0] oldWord_c;
    logic          push;
    logic          clr;

    pushshift_ram #(
        .DW(DW),
        .AW(AW)
    ) uRam (
        .sysclk   (sysclk),
        .we       (ramWe),
        .addr     (ramAddr),
        .wrData   (ramWrData),
        .rdData_c (oldWord_c)
    );

    // State register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next state, sweep counter and RAM port steering; a clear always beats a push
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        ramWe     = 1'b0;
        ramAddr   = iAddr;
        ramWrData = iData;
        push      = 1'b0;
        clr       = 1'b0;
        case (state)
            ST_INIT: begin
                ramWe     = 1'b1;
                ramAddr   = cnt;
                ramWrData = '0;
                if (iClr) begin
                    cntNext = '0;
                end else if (cnt == {AW{1'b1}}) begin
                    cntNext   = '0;
                    stateNext = ST_IDLE;
                end else begin
                    cntNext = cnt + AW'(1);
                end
            end
            ST_IDLE: begin
                if (iClr) begin
                    clr       = 1'b1;
                    cntNext   = '0;
                    stateNext = ST_INIT;
                end else if (iEn) begin
                    push  = 1'b1;
                    ramWe = 1'b1;
                end
            end
            default: begin
                stateNext = ST_INIT;
            end
        endcase
    end

    // Registered outputs: digit shift register, ready flag and done pulse
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            oData  <= '0;
            oReady <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            oReady <= (stateNext == ST_IDLE);
            oDone  <= push;
            if (clr) begin
                oData <= '0;
            end else if (push) begin
                if (iDir) begin
                    oData <= {oldWord_c, oData[OW-1:DW]};
                end else begin
                    oData <= {oData[OW-DW-1:0], oldWord_c};
                end
            end
        end
    end

endmodule

// File: tb/tb_pushshift_bank.sv
// Scoreboard bench for pushshift_bank against a digit-array / word-array reference model.
module tb_pushshift_bank;

    localparam int unsigned DW     = 4;
    localparam int unsigned DIGITS = 6;
    localparam int unsigned AW     = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned OW     = DW * DIGITS;

    logic          sysclk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          iEn    = 1'b0;
    logic          iDir   = 1'b0;
    logic          iClr   = 1'b0;
    logic [AW-1:0] iAddr  = '0;
    logic [DW-1:0] iData  = '0;
    logic [OW-1:0] oData;
    logic          oReady;
    logic          oDone;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;

    int mref [DEPTH];
    int dig  [DIGITS];
    logic [OW-1:0] sbq [$];

    pushshift_bank #(
        .DW(DW),
        .DIGITS(DIGITS),
        .AW(AW)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .iEn    (iEn),
        .iDir   (iDir),
        .iClr   (iClr),
        .iAddr  (iAddr),
        .iData  (iData),
        .oData  (oData),
        .oReady (oReady),
        .oDone  (oDone)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] packDigits();
        logic [OW-1:0] v = '0;
        for (int k = 0; k < DIGITS; k++) v[k*DW +: DW] = DW'(dig[k]);
        return v;
    endfunction

    function automatic void modelClear();
        for (int a = 0; a < DEPTH; a++) mref[a] = 0;
        for (int k = 0; k < DIGITS; k++) dig[k] = 0;
    endfunction

    // Monitor: every oDone pulse must match the oldest outstanding push
    always @(negedge sysclk) begin
        if (rst_n && oDone === 1'b1) begin
            doneCount++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got oDone=1 expected no pending push at %0t", $time);
            end else begin
                logic [OW-1:0] exp;
                exp = sbq.pop_front();
                chk("push_data", 32'(oData), 32'(exp));
            end
        end
    end

    task automatic pushOp(input bit dir, input int addr, input int data);
        int old;
        old = mref[addr];
        mref[addr] = data;
        if (!dir) begin
            for (int k = DIGITS - 1; k > 0; k--) dig[k] = dig[k-1];
            dig[0] = old;
        end else begin
            for (int k = 0; k < DIGITS - 1; k++) dig[k] = dig[k+1];
            dig[DIGITS-1] = old;
        end
        sbq.push_back(packDigits());
        iEn   = 1'b1;
        iDir  = dir;
        iAddr = AW'(addr);
        iData = DW'(data);
        @(posedge sysclk); #1;
        iEn = 1'b0;
    endtask

    // Counts edges until oReady rises, hammering iEn meanwhile (must be ignored)
    task automatic waitReady(input string name, input int expEdges);
        int n = 0;
        while (oReady !== 1'b1 && n < 100) begin
            iEn   = 1'($urandom_range(0, 1));
            iAddr = AW'($urandom);
            iData = DW'($urandom);
            @(posedge sysclk); #1;
            n++;
        end
        iEn = 1'b0;
        chk(name, 32'(n), 32'(expEdges));
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        sbq.delete();
        modelClear();
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_ready", 32'(oReady), 32'd0);
        chk("rst_data", 32'(oData), 32'd0);
        chk("rst_done", 32'(oDone), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic clearOp(input bit withPush);
        iClr  = 1'b1;
        iEn   = withPush;
        iAddr = AW'($urandom);
        iData = DW'($urandom);
        @(posedge sysclk); #1;
        iClr = 1'b0;
        iEn  = 1'b0;
        modelClear();
        chk("clr_data", 32'(oData), 32'd0);
        chk("clr_ready", 32'(oReady), 32'd0);
        waitReady("clr_init_len", 16);
    endtask

    initial begin
        modelClear();
        @(posedge sysclk); #1;
        resetDut();
        waitReady("init_len", 16);

        // First push after sweep reads a cleared word
        pushOp(0, 0, 7);
        chk("first_push", 32'(oData), 32'h000000);

        // Back-to-back pushes to one address
        clearOp(0);
        begin
            int d0;
            d0 = doneCount;
            pushOp(0, 5, 1);
            pushOp(0, 5, 2);
            pushOp(0, 5, 3);
            pushOp(0, 5, 4);
            chk("same_addr_low", 32'(oData[DW-1:0]), 32'd3);
            chk("same_addr_all", 32'(oData), 32'h000123);
            @(negedge sysclk); #1;
            chk("done_pulses", 32'(doneCount - d0), 32'd4);
        end

        // Preload A..F then read back with zero writes
        for (int a = 0; a < 6; a++) pushOp(0, a, 10 + a);
        for (int a = 0; a < 6; a++) pushOp(0, a, 0);
        pushOp(0, 0, 0);
        chk("readback_left", 32'(oData), 32'hBCDEF0);

        // Build 0x123456 then right-push a 9
        clearOp(0);
        for (int a = 1; a <= 6; a++) pushOp(0, a, a);
        pushOp(0, 9, 9);
        for (int a = 1; a <= 6; a++) pushOp(0, a, 0);
        chk("build_123456", 32'(oData), 32'h123456);
        pushOp(1, 9, 0);
        chk("right_push", 32'(oData), 32'h912345);

        // Clear with simultaneous push: push dropped, RAM re-zeroed
        pushOp(0, 3, 5);
        clearOp(1);
        pushOp(0, 3, 8);
        chk("after_clr_read", 32'(oData), 32'h000000);

        // Clear during INIT restarts the sweep
        iClr = 1'b1;
        @(posedge sysclk); #1;
        iClr = 1'b0;
        modelClear();
        repeat (5) begin @(posedge sysclk); #1; end
        clearOp(0);

        // Async reset mid-sweep at cnt=7
        resetDut();
        repeat (7) begin @(posedge sysclk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("midinit_rst_ready", 32'(oReady), 32'd0);
        chk("midinit_rst_data", 32'(oData), 32'd0);
        @(posedge sysclk); #1;
        rst_n = 1'b1;
        waitReady("midinit_len", 16);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) clearOp(1'($urandom_range(0, 1)));
            else if (r < 20) begin @(posedge sysclk); #1; end
            else pushOp(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                        int'($urandom_range(0, (1 << DW) - 1)));
        end

        repeat (3) @(posedge sysclk);
        @(negedge sysclk); #1;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
